// File: rtl/fetch_stage.sv
// fetch_stage -- instruction-fetch stage that writes the fetch/decode boundary.
//
// It owns the program counter (PC) and drives the instruction-memory address
// combinationally from it. Each cycle it registers one of three things toward
// decode: the fetched word with its PC and PC+4, a bubble, or (under a stall)
// the values it already holds. After reset it sends BOOT_BUBBLES bubble cycles
// before the first fetch.
//
// Ports:
//   Clk            rising-edge clock
//   Reset          synchronous, active-high reset
//   Stall          hazard stall from decode; PC and outputs hold
//   Flush          squash the word currently being fetched; PC holds
//   BranchTaken    taken branch; redirect to BranchTarget
//   BranchTarget   branch destination (bits [1:0] ignored)
//   Jump           jump; redirect to JumpTarget; wins over a branch
//   JumpTarget     jump destination (bits [1:0] ignored)
//   ImemAddr       instruction-memory address, always equal to PC
//   ImemData       word at ImemAddr, asynchronous read in the same cycle
//   InstructionOut registered instruction to decode
//   PC4Out         registered PC+4 of InstructionOut
//   PCOut          registered PC of InstructionOut
//   ValidOut       1 = real fetch, 0 = bubble
//   FetchCount     number of valid instructions delivered (wraps)

module fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD     = 32'h0000_0000,
  parameter int unsigned BOOT_BUBBLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemData,
  output logic [31:0] InstructionOut,
  output logic [31:0] PC4Out,
  output logic [31:0] PCOut,
  output logic        ValidOut,
  output logic [31:0] FetchCount
);

  typedef enum logic {BOOT, RUN} state_t;

  localparam logic [3:0] BOOT_CNT   = 4'(BOOT_BUBBLES);
  localparam state_t     BOOT_STATE = (BOOT_BUBBLES == 0) ? RUN : BOOT;

  state_t      state, state_nxt;
  logic [3:0]  bub_cnt, bub_cnt_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] instr_nxt, pc4_nxt, pcout_nxt, cnt_nxt;
  logic        valid_nxt;
  logic [31:0] redir_tgt;

  assign ImemAddr  = pc;
  // When both redirects are asserted, the jump wins.
  assign redir_tgt = (Jump ? JumpTarget : BranchTarget) & ~32'h3;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= BOOT_STATE;
      bub_cnt        <= BOOT_CNT;
      pc             <= RESET_PC;
      InstructionOut <= NOP_WORD;
      PC4Out         <= '0;
      PCOut          <= '0;
      ValidOut       <= 1'b0;
      FetchCount     <= '0;
    end else begin
      state          <= state_nxt;
      bub_cnt        <= bub_cnt_nxt;
      pc             <= pc_nxt;
      InstructionOut <= instr_nxt;
      PC4Out         <= pc4_nxt;
      PCOut          <= pcout_nxt;
      ValidOut       <= valid_nxt;
      FetchCount     <= cnt_nxt;
    end
  end

  always_comb begin
    // By default every register holds its value, which is exactly what a stall needs.
    state_nxt   = state;
    bub_cnt_nxt = bub_cnt;
    pc_nxt      = pc;
    instr_nxt   = InstructionOut;
    pc4_nxt     = PC4Out;
    pcout_nxt   = PCOut;
    valid_nxt   = ValidOut;
    cnt_nxt     = FetchCount;

    if (state == BOOT) begin
      // Every hazard and redirect input is ignored. The counter never goes below zero.
      instr_nxt = NOP_WORD;
      valid_nxt = 1'b0;
      pc4_nxt   = '0;
      pcout_nxt = '0;
      if (bub_cnt != 4'd0) bub_cnt_nxt = bub_cnt - 4'd1;
      if (bub_cnt <= 4'd1) state_nxt = RUN;
    end else begin
      if (Jump || BranchTaken) begin
        pc_nxt    = redir_tgt;
        instr_nxt = NOP_WORD;
        valid_nxt = 1'b0;
        pc4_nxt   = '0;
        pcout_nxt = '0;
      end else if (Flush) begin
        // PC holds, so the squashed address is fetched again next cycle.
        instr_nxt = NOP_WORD;
        valid_nxt = 1'b0;
        pc4_nxt   = '0;
        pcout_nxt = '0;
      end else if (!Stall) begin
        instr_nxt = ImemData;
        pcout_nxt = pc;
        pc4_nxt   = pc + 32'd4;
        valid_nxt = 1'b1;
        pc_nxt    = pc + 32'd4;
        cnt_nxt   = FetchCount + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. The run has two parts: directed
// scenarios built from the stated fetch rules, then a randomized phase. Each
// cycle the bench compares every output against a behavioural model that
// keeps the fetch stream as plain values: PC, the last delivered record and
// the count of boot cycles left.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam int          BOOT     = 2;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Flush, BranchTaken, Jump;
  logic [31:0] BranchTarget, JumpTarget;
  logic [31:0] ImemAddr, ImemData;
  logic [31:0] InstructionOut, PC4Out, PCOut, FetchCount;
  logic        ValidOut;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h2008_0005;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign ImemData = mem_word(ImemAddr);

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_WORD(NOP), .BOOT_BUBBLES(BOOT)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget),
    .ImemAddr(ImemAddr), .ImemData(ImemData),
    .InstructionOut(InstructionOut), .PC4Out(PC4Out), .PCOut(PCOut),
    .ValidOut(ValidOut), .FetchCount(FetchCount)
  );

  // Reference model
  logic [31:0] m_pc, m_instr, m_pc4, m_pcout, m_cnt;
  logic        m_valid;
  int          m_boot_left;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic bubble();
    m_instr = NOP; m_valid = 1'b0; m_pc4 = '0; m_pcout = '0;
  endtask

  // Advances the model by one clock edge, using the inputs as they stood before the edge.
  task automatic model_step();
    if (Reset) begin
      m_pc = RESET_PC; bubble(); m_cnt = '0; m_boot_left = BOOT;
    end else if (m_boot_left > 0) begin
      m_boot_left--;
      bubble();
    end else if (Jump) begin
      m_pc = {JumpTarget[31:2], 2'b00}; bubble();
    end else if (BranchTaken) begin
      m_pc = {BranchTarget[31:2], 2'b00}; bubble();
    end else if (Flush) begin
      bubble();
    end else if (!Stall) begin
      m_instr = mem_word(m_pc); m_pcout = m_pc; m_pc4 = m_pc + 4; m_valid = 1'b1;
      m_pc = m_pc + 4; m_cnt = m_cnt + 1;
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
    chk("ImemAddr", ImemAddr, m_pc);
    chk("InstructionOut", InstructionOut, m_instr);
    chk("PCOut", PCOut, m_pcout);
    chk("PC4Out", PC4Out, m_pc4);
    chk("ValidOut", {31'd0, ValidOut}, {31'd0, m_valid});
    chk("FetchCount", FetchCount, m_cnt);
  endtask

  task automatic idle();
    Reset = 0; Stall = 0; Flush = 0; BranchTaken = 0; Jump = 0;
  endtask

  task automatic jump_to(input logic [31:0] t);
    Jump = 1; JumpTarget = t; tick(); Jump = 0;
  endtask

  initial begin
    idle();
    BranchTarget = '0; JumpTarget = '0;
    m_pc = '0; m_instr = NOP; m_pc4 = '0; m_pcout = '0; m_cnt = '0; m_valid = 0; m_boot_left = 0;

    // Boot: reset held for two cycles, then two bubble cycles, then sequential fetch.
    Reset = 1; tick(); tick();
    chk("reset_valid", {31'd0, ValidOut}, 32'd0);
    chk("reset_pc", ImemAddr, 32'h100);
    Reset = 0;
    tick(); tick();
    chk("boot_bubble", {31'd0, ValidOut}, 32'd0);
    tick();
    chk("first_instr", InstructionOut, 32'h2008_0005);
    chk("first_pc4", PC4Out, 32'h104);
    chk("first_cnt", FetchCount, 32'd1);
    tick(); tick();  // fetches at 0x104 and 0x108; PC is now 0x10C

    // Stall held for three cycles at PC 0x10C.
    Stall = 1; repeat (3) tick();
    chk("stall_addr", ImemAddr, 32'h10C);
    Stall = 0; tick();
    chk("post_stall_pc", PCOut, 32'h10C);
    chk("post_stall_cnt", FetchCount, 32'd4);

    // Branch and jump in the same cycle as a stall: the jump wins.
    jump_to(32'h200);
    BranchTaken = 1; BranchTarget = 32'h3F3; Jump = 1; JumpTarget = 32'h400; Stall = 1;
    tick(); idle();
    chk("jump_wins", ImemAddr, 32'h400);
    tick();
    chk("jump_pcout", PCOut, 32'h400);
    BranchTaken = 1; BranchTarget = 32'h3F3; tick(); idle();
    chk("branch_align", ImemAddr, 32'h3F0);
    tick();

    // Flush at PC 0x500: the same address is fetched again afterwards.
    jump_to(32'h500);
    Flush = 1; tick(); Flush = 0;
    chk("flush_addr", ImemAddr, 32'h500);
    tick();
    chk("flush_refetch", PCOut, 32'h500);

    // PC wraps from 0xFFFF_FFFC to 0.
    jump_to(32'hFFFF_FFFC);
    tick();
    chk("wrap_pc4", PC4Out, 32'h0);
    chk("wrap_addr", ImemAddr, 32'h0);
    tick();

    // Reset during an active stall at 0x240; the stall level is ignored while in boot.
    jump_to(32'h240);
    Stall = 1; tick();
    Reset = 1; tick(); Reset = 0;
    chk("rst_stall_cnt", FetchCount, 32'd0);
    repeat (4) tick();
    Stall = 0; repeat (3) tick();

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      Reset       = ($urandom % 250) == 0;
      Stall       = ($urandom % 4) == 0;
      Flush       = ($urandom % 9) == 0;
      BranchTaken = ($urandom % 11) == 0;
      Jump        = ($urandom % 13) == 0;
      BranchTarget = $urandom;
      JumpTarget   = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
